// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_ILEN       = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned PC_INCR        = 4;

  // A redirect target is misaligned when either of its byte-offset bits is set.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with push/pop/flush and an occupancy count.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;
  logic             push_ok;

  // Pop on empty is ignored; push on full is only legal alongside a pop.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited pipelined
// memory requests, buffers responses and drops in-flight responses after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = DEF_XLEN,
  parameter int unsigned     ILEN         = DEF_ILEN,
  parameter int unsigned     FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  output logic            misalign_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = XLEN + ILEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            misalign_q, misalign_d;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;
  logic [XLEN-1:0] target_pc;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_keep;
  logic            pop;

  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

  // Every in-flight request reserves a buffer slot, so a returning word always fits.
  assign credit_ok = (SW'(outstanding_q) + SW'(fifo_count)) < SW'(FIFO_DEPTH);
  assign imem_req  = reset && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc_q;
  assign req_fire  = imem_req && imem_gnt;
  assign resp_keep = imem_rvalid && (drop_q == '0) && !redirect_valid;
  assign pop       = if_valid && if_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rvalid);
    misalign_d    = redirect_valid && misaligned(redirect_pc[1:0]);

    if (redirect_valid) begin
      // Everything still in flight, bar a response landing this cycle, is stale.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
      end
      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + XLEN'(PC_INCR);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_q        <= '0;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      misalign_q    <= misalign_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (resp_keep),
    .data_i  ({resp_pc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign if_valid     = (fifo_count != '0);
  assign if_pc        = fifo_head[EW-1:ILEN];
  assign if_instr     = fifo_head[ILEN-1:0];
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder plus an epoch-tagged fetch stream model.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;

  fetch_unit #(
    .XLEN         (32),
    .ILEN         (32),
    .FIFO_DEPTH   (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          due;
    int          epoch;
  } req_t;

  req_t        mq[$];   // accepted requests awaiting a response
  logic [31:0] fq[$];   // PCs expected to be buffered for decode
  int          cyc, epoch, last_due;
  int          gnt_pct, lat_min, lat_max;
  int          n_checks, n_pass;
  logic [31:0] next_fetch;
  logic        exp_mis;
  logic        s_req, s_valid, s_mis, s_pop;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_init();
    mq.delete();
    fq.delete();
    epoch      = 0;
    last_due   = 0;
    next_fetch = RV;
    exp_mis    = 1'b0;
  endtask

  // One clock: drive memory, sample at #1, score the cycle, advance the model.
  task automatic tick();
    req_t r;
    logic exp_req;
    logic keep;
    int   d;
    imem_gnt = (int'($urandom_range(99)) < gnt_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
    s_pc = if_pc; s_instr = if_instr; s_mis = misalign_err;
    s_pop = if_valid && if_ready;

    exp_req = !redirect_valid && ((mq.size() + fq.size()) < DEPTH);
    n_checks++;
    if (imem_req !== exp_req) $display("FAIL imem_req @%0d: got %b want %b", cyc, imem_req, exp_req);
    else n_pass++;
    if (exp_req) begin
      n_checks++;
      if (imem_addr !== next_fetch) $display("FAIL imem_addr @%0d: got %h want %h", cyc, imem_addr, next_fetch);
      else n_pass++;
    end
    n_checks++;
    if (if_valid !== (fq.size() != 0)) $display("FAIL if_valid @%0d: got %b want %b", cyc, if_valid, fq.size() != 0);
    else n_pass++;
    if (fq.size() != 0) begin
      n_checks++;
      if (if_pc !== fq[0] || if_instr !== mem_word(fq[0]))
        $display("FAIL if_entry @%0d: got %h/%h want %h/%h", cyc, if_pc, if_instr, fq[0], mem_word(fq[0]));
      else n_pass++;
    end
    n_checks++;
    if (misalign_err !== exp_mis) $display("FAIL misalign_err @%0d: got %b want %b", cyc, misalign_err, exp_mis);
    else n_pass++;

    keep = 1'b0;
    r    = '{default: 0};
    if (imem_rvalid) begin
      r    = mq.pop_front();
      keep = (r.epoch == epoch) && !redirect_valid;
    end
    if (redirect_valid) begin
      fq.delete();
      epoch++;
      next_fetch = {redirect_pc[31:2], 2'b00};
      exp_mis    = (redirect_pc[1:0] != 2'b00);
    end else begin
      exp_mis = 1'b0;
      if (s_pop && fq.size() > 0) fq.delete(0);
      if (keep) fq.push_back(r.pc);
      if (imem_req && imem_gnt) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d < last_due) d = last_due;
        last_due = d;
        mq.push_back('{imem_addr, next_fetch, d, epoch});
        next_fetch = next_fetch + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) $display("FAIL reset_ctrl: got req=%b valid=%b want 0/0", imem_req, if_valid);
    else n_pass++;
    n_checks++;
    if (if_pc !== 32'h0 || if_instr !== 32'h0) $display("FAIL reset_data: got %h/%h want 0/0", if_pc, if_instr);
    else n_pass++;
    n_checks++;
    if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign_err);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    model_init();
  endtask

  task automatic test_stream();
    int first;
    gnt_pct = 100; lat_min = 1; lat_max = 1; if_ready = 1'b1; first = -1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 1) begin
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== RV) $display("FAIL first_req: got %b/%h want 1/%h", s_req, s_addr, RV);
        else n_pass++;
      end
      if (s_valid && first < 0) first = i;
    end
    n_checks++;
    if (first !== 3) $display("FAIL first_valid_cycle: got %0d want 3", first);
    else n_pass++;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if (s_pop !== 1'b1 || s_pc !== RV + 32'(4 * k)) $display("FAIL stream_pc: got %b/%h want 1/%h", s_pop, s_pc, RV + 32'(4 * k));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int pops;
    if_ready = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1) $display("FAIL bp_full: got req=%b valid=%b want 0/1", s_req, s_valid);
    else n_pass++;
    gnt_pct = 0; if_ready = 1'b1; pops = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_pop) pops++;
    end
    n_checks++;
    if (pops !== DEPTH) $display("FAIL bp_drain: got %0d want %0d", pops, DEPTH);
    else n_pass++;
  endtask

  task automatic test_redirect_stale();
    logic found;
    lat_min = 3; lat_max = 3; gnt_pct = 0; if_ready = 1'b1;
    repeat (8) tick();
    gnt_pct = 100;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h100) $display("FAIL stale_req: got %b/%h want 1/00000100", s_req, s_addr);
    else n_pass++;
    found = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (s_valid && !found) begin
        found = 1'b1;
        n_checks++;
        if (i !== 5 || s_pc !== 32'h100) $display("FAIL stale_first: got cyc+%0d pc %h want cyc+5 pc 00000100", i, s_pc);
        else n_pass++;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL stale_timeout: got no if_valid want pc 00000100");
    end
  endtask

  task automatic test_misalign();
    lat_min = 1; lat_max = 1; gnt_pct = 100; if_ready = 1'b1;
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (s_mis !== 1'b1 || s_addr !== 32'h200) $display("FAIL misalign_pulse: got %b/%h want 1/00000200", s_mis, s_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (s_mis !== 1'b0) $display("FAIL misalign_width: got %b want 0", s_mis);
    else n_pass++;
    tick();
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h200) $display("FAIL misalign_target: got %b/%h want 1/00000200", s_valid, s_pc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0401;
    tick();
    redirect_pc = 32'h0000_080C;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (s_addr !== 32'h80C || s_mis !== 1'b0) $display("FAIL b2b_addr: got %h/%b want 0000080c/0", s_addr, s_mis);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h80C) $display("FAIL b2b_target: got %b/%h want 1/0000080c", s_valid, s_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic saw0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0; saw0 = 1'b0;
    repeat (8) begin
      tick();
      if (s_pop && s_pc == 32'h0) saw0 = 1'b1;
    end
    n_checks++;
    if (saw0 !== 1'b1) $display("FAIL wrap: got no pc 0 after fffffffc want pc 00000000");
    else n_pass++;
  endtask

  task automatic test_random();
    int pops;
    lat_min = 1; lat_max = 3; gnt_pct = 50; pops = 0;
    for (int i = 0; i < 1500; i++) begin
      if_ready       = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 3);
      redirect_pc    = $urandom;
      tick();
      if (s_pop && !redirect_valid) pops++;
    end
    redirect_valid = 1'b0;
    n_checks++;
    if (pops <= 100) $display("FAIL random_progress: got %0d pops want >100", pops);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic found;
    lat_min = 1; lat_max = 1; gnt_pct = 100; if_ready = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (s_valid !== 1'b1 || s_req !== 1'b0) $display("FAIL rm_full: got valid=%b req=%b want 1/0", s_valid, s_req);
    else n_pass++;
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL rm_clear: got valid=%b req=%b want 0/0", if_valid, imem_req);
    else n_pass++;
    n_checks++;
    if (if_pc !== 32'h0 || if_instr !== 32'h0) $display("FAIL rm_data: got %h/%h want 0/0", if_pc, if_instr);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1; if_ready = 1'b1;
    model_init();
    tick();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RV) $display("FAIL rm_restart: got %b/%h want 1/%h", s_req, s_addr, RV);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_valid && !found) begin
        found = 1'b1;
        n_checks++;
        if (s_pc !== RV) $display("FAIL rm_first_pc: got %h want %h", s_pc, RV);
        else n_pass++;
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL rm_timeout: got no if_valid want pc %h", RV);
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    model_init();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_misalign();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
